// File: rtl/uc_arbiter.sv
// Round-robin push arbiter plus pop/broadcast FSM for a shared unit clause queue; grants are combinational, broadcast is registered.
// Pushes stall on q_full or flush; a broadcast holds until every engine has acked, or until flush abandons it.
module uc_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 10,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_ENG-1:0]              eng_valid,
  input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng_lit,
  output logic [NUM_ENG-1:0]              eng_grant,
  output logic                            q_push,
  output logic signed [LIT_W-1:0]         q_data,
  output logic                            q_pop,
  input  logic                            q_full,
  input  logic                            q_empty,
  input  logic signed [LIT_W-1:0]         q_out,
  input  logic                            flush,
  output logic                            bc_valid,
  output logic signed [LIT_W-1:0]         bc_lit,
  input  logic [NUM_ENG-1:0]              bc_ack,
  output logic                            busy,
  output logic [CNT_W-1:0]                bc_cnt
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BCAST = 1'b1;

  logic [0:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               push_en;
  logic [NUM_ENG-1:0] ack_mask;
  logic [NUM_ENG-1:0] ack_next;
  int                 scan_idx;

  // First requester at or after rr_ptr, wrapping around the engine ring.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int off = 0; off < NUM_ENG; off++) begin
      scan_idx = (int'(rr_ptr) + off) % NUM_ENG;
      if (!grant_any && eng_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
  end

  assign push_en = grant_any && !q_full && !flush && !rst;
  assign q_push  = push_en;
  assign q_data  = push_en ? eng_lit[grant_idx] : '0;

  always_comb begin
    eng_grant = '0;
    if (push_en) eng_grant[grant_idx] = 1'b1;
  end

  assign ack_next = ack_mask | bc_ack;
  assign q_pop    = (state == IDLE) && !q_empty && !flush && !rst;
  assign bc_valid = (state == BCAST) && !rst;
  assign busy     = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push_en) begin
      if (int'(grant_idx) == NUM_ENG - 1) rr_ptr <= '0;
      else                                rr_ptr <= grant_idx + 1'b1;
    end
  end

  // Flush wins over a completing ack set: the popped literal is dropped uncounted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack_mask <= '0;
      bc_lit   <= '0;
      bc_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_pop) begin
            bc_lit   <= q_out;
            ack_mask <= '0;
            state    <= BCAST;
          end
        end
        BCAST: begin
          if (flush) begin
            ack_mask <= '0;
            state    <= IDLE;
          end else if (&ack_next) begin
            ack_mask <= '0;
            state    <= IDLE;
            if (bc_cnt != {CNT_W{1'b1}}) bc_cnt <= bc_cnt + 1'b1;
          end else begin
            ack_mask <= ack_next;
          end
        end
        default: begin
          ack_mask <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
// Bench for uc_arbiter: abstract reference model checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_uc_arbiter;
  localparam int N  = 4;
  localparam int LW = 10;
  localparam int CW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          eng_valid;
  logic [N-1:0][LW-1:0]  eng_lit;
  logic [N-1:0]          eng_grant;
  logic                  q_push;
  logic signed [LW-1:0]  q_data;
  logic                  q_pop;
  logic                  q_full;
  logic                  q_empty;
  logic signed [LW-1:0]  q_out;
  logic                  flush;
  logic                  bc_valid;
  logic signed [LW-1:0]  bc_lit;
  logic [N-1:0]          bc_ack;
  logic                  busy;
  logic [CW-1:0]         bc_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  int           m_rr;
  bit           m_bcast;
  logic [LW-1:0] m_lit;
  bit           m_acked [N];
  int           m_cnt;

  uc_arbiter #(.NUM_ENG(N), .LIT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .eng_valid(eng_valid), .eng_lit(eng_lit),
    .eng_grant(eng_grant), .q_push(q_push), .q_data(q_data), .q_pop(q_pop),
    .q_full(q_full), .q_empty(q_empty), .q_out(q_out), .flush(flush),
    .bc_valid(bc_valid), .bc_lit(bc_lit), .bc_ack(bc_ack), .busy(busy),
    .bc_cnt(bc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (rst || q_full || flush) return -1;
    for (int off = 0; off < N; off++)
      if (eng_valid[(m_rr + off) % N]) return (m_rr + off) % N;
    return -1;
  endfunction

  function automatic bit exp_pop();
    return !rst && !m_bcast && !q_empty && !flush;
  endfunction

  always @(posedge clk) begin
    int  g;
    bit  all;
    g = exp_grant();
    if (rst) begin
      m_rr = 0; m_bcast = 0; m_lit = '0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_acked[i] = 0;
    end else begin
      if (g >= 0) m_rr = (g + 1) % N;
      if (!m_bcast) begin
        if (exp_pop()) begin
          m_bcast = 1; m_lit = {q_out};
          for (int i = 0; i < N; i++) m_acked[i] = 0;
        end
      end else if (flush) begin
        m_bcast = 0;
        for (int i = 0; i < N; i++) m_acked[i] = 0;
      end else begin
        all = 1;
        for (int i = 0; i < N; i++) begin
          if (bc_ack[i]) m_acked[i] = 1;
          if (!m_acked[i]) all = 0;
        end
        if (all) begin
          m_bcast = 0;
          if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (cmp_en) begin
      g = exp_grant();
      chk("m_eng_grant", {28'd0, eng_grant}, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("m_q_push", {31'd0, q_push}, {31'd0, (g >= 0)});
      if (g >= 0) chk("m_q_data", {22'd0, {q_data}}, {22'd0, eng_lit[g]});
      chk("m_q_pop", {31'd0, q_pop}, {31'd0, exp_pop()});
      chk("m_bc_valid", {31'd0, bc_valid}, {31'd0, (!rst && m_bcast)});
      chk("m_busy", {31'd0, busy}, {31'd0, (!rst && m_bcast)});
      chk("m_bc_lit", {22'd0, {bc_lit}}, {22'd0, m_lit});
      chk("m_bc_cnt", {29'd0, bc_cnt}, m_cnt);
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; eng_valid = 4'b1111; q_full = 1'b0; q_empty = 1'b0;
    q_out = '0; flush = 1'b0; bc_ack = '0;
    eng_lit[0] = 10'd17; eng_lit[1] = 10'h3FD; eng_lit[2] = 10'd200; eng_lit[3] = 10'h200;
    next_cycle();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_grant", {28'd0, eng_grant}, 32'd0);
    chk("rst_pop", {31'd0, q_pop}, 32'd0);
    chk("rst_cnt", {29'd0, bc_cnt}, 32'd0);
    next_cycle();
    rst = 1'b0; q_empty = 1'b1;

    // Fairness: all four requesting
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fair_grant", {28'd0, eng_grant}, 32'd1 << (i % 4));
      next_cycle();
    end
    eng_valid = 4'b1001;
    @(negedge clk);
    chk("fair_rr_wrap", {28'd0, eng_grant}, 32'd1);
    next_cycle();

    // Backpressure
    eng_valid = 4'b0100; q_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {28'd0, eng_grant}, 32'd0);
      next_cycle();
    end
    q_full = 1'b0;
    @(negedge clk);
    chk("bp_grant", {28'd0, eng_grant}, 32'h4);
    chk("bp_data", {22'd0, {q_data}}, 32'd200);
    next_cycle();
    eng_valid = '0;

    // Broadcast of -5 with split acks
    q_empty = 1'b0; q_out = -10'sd5;
    @(negedge clk);
    chk("bc_pop", {31'd0, q_pop}, 32'd1);
    next_cycle();
    q_empty = 1'b1; bc_ack = 4'b0011;
    @(negedge clk);
    chk("bc_valid", {31'd0, bc_valid}, 32'd1);
    chk("bc_lit", {22'd0, {bc_lit}}, 32'h3FB);
    next_cycle();
    bc_ack = 4'b1100;
    next_cycle();
    bc_ack = '0;
    @(negedge clk);
    chk("bc_done_valid", {31'd0, bc_valid}, 32'd0);
    chk("bc_done_cnt", {29'd0, bc_cnt}, 32'd1);
    next_cycle();

    // Flush during broadcast after a partial ack
    q_empty = 1'b0; q_out = 10'sd7;
    next_cycle();
    q_empty = 1'b1; bc_ack = 4'b0001;
    next_cycle();
    bc_ack = '0; flush = 1'b1; eng_valid = 4'b0010;
    @(negedge clk);
    chk("fl_no_grant", {28'd0, eng_grant}, 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", {31'd0, bc_valid}, 32'd0);
    chk("fl_cnt", {29'd0, bc_cnt}, 32'd1);
    next_cycle();
    eng_valid = '0;

    // Flush in IDLE suppresses pop, then simultaneous push and pop
    q_empty = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_pop", {31'd0, q_pop}, 32'd0);
    next_cycle();
    flush = 1'b0; eng_valid = 4'b0010; q_out = 10'sd3;
    @(negedge clk);
    chk("pp_push", {31'd0, q_push}, 32'd1);
    chk("pp_pop", {31'd0, q_pop}, 32'd1);
    next_cycle();

    // Reset in the middle of a broadcast
    q_empty = 1'b1; rst = 1'b1; eng_valid = 4'b1111;
    @(negedge clk);
    chk("rm_busy_in_rst", {31'd0, busy}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_cnt", {29'd0, bc_cnt}, 32'd0);
    chk("rm_rr", {28'd0, eng_grant}, 32'd1);
    next_cycle();
    eng_valid = '0;

    // Back-to-back broadcasts: pop every other cycle, counter saturates at 7
    q_empty = 1'b0; bc_ack = 4'b1111;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      chk("sp_pop", {31'd0, q_pop}, {31'd0, (j % 2 == 0)});
      next_cycle();
      q_out = LW'(j + 1);
    end
    q_empty = 1'b1; bc_ack = '0;
    @(negedge clk);
    chk("sat_cnt", {29'd0, bc_cnt}, 32'd7);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
